// File: rtl/word_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : word_serializer
//  Description : Parallel-to-serial front end. Accepts WIDTH-bit words over a
//                valid/ready handshake and emits them one bit per cycle, LSB
//                first, onto the serial input of a free-running downstream
//                shift register. frame_done marks the one cycle in which that
//                downstream register holds the complete word.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1            rising-edge clock
//    rst_n        in   1            synchronous active-low reset
//    in_valid     in   1            upstream word available
//    in_ready     out  1            word can be accepted this cycle
//    in_data      in   WIDTH        word to serialize (sampled on accept)
//    serial_out   out  1            registered serial bit
//    bit_valid    out  1            serial_out carries a frame bit
//    frame_done   out  1            one-cycle pulse after the last bit
//    frame_count  out  COUNT_WIDTH  completed frames, wrapping
// ============================================================================
module word_serializer #(
    parameter int   WIDTH       = 4,
    parameter logic IDLE_BIT    = 1'b0,
    parameter int   COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   serial_out,
    output logic                   bit_valid,
    output logic                   frame_done,
    output logic [COUNT_WIDTH-1:0] frame_count
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                 r_state,     w_state_nxt;
    logic [WIDTH-1:0]       r_shift,     w_shift_nxt;
    logic [CNT_W-1:0]       r_cnt,       w_cnt_nxt;
    logic                   r_serial,    w_serial_nxt;
    logic                   r_bit_valid, w_bit_valid_nxt;
    logic                   r_done,      w_done_nxt;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_last;
    logic                   w_accept;

    // The last bit of a frame is on serial_out; a new word may be taken now
    // so that consecutive frames run without a gap.
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == c_LAST);
    assign in_ready = (r_state == S_IDLE) || w_last;
    assign w_accept = in_valid && in_ready;

    // r_shift holds only the bits not yet presented; bit 0 of a new word goes
    // straight into the serial output register on accept.
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = r_cnt;
        w_serial_nxt    = r_serial;
        w_bit_valid_nxt = r_bit_valid;
        w_done_nxt      = w_last;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt     = S_SHIFT;
                    w_serial_nxt    = in_data[0];
                    w_shift_nxt     = in_data >> 1;
                    w_cnt_nxt       = '0;
                    w_bit_valid_nxt = 1'b1;
                end else begin
                    w_serial_nxt    = IDLE_BIT;
                    w_bit_valid_nxt = 1'b0;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    if (w_accept) begin
                        w_state_nxt     = S_SHIFT;
                        w_serial_nxt    = in_data[0];
                        w_shift_nxt     = in_data >> 1;
                        w_cnt_nxt       = '0;
                        w_bit_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = S_IDLE;
                        w_serial_nxt    = IDLE_BIT;
                        w_bit_valid_nxt = 1'b0;
                    end
                end else begin
                    w_serial_nxt = r_shift[0];
                    w_shift_nxt  = r_shift >> 1;
                    w_cnt_nxt    = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_serial_nxt    = IDLE_BIT;
                w_bit_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_serial    <= IDLE_BIT;
            r_bit_valid <= 1'b0;
            r_done      <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_serial    <= w_serial_nxt;
            r_bit_valid <= w_bit_valid_nxt;
            r_done      <= w_done_nxt;
            // Counter steps on the same edge that raises frame_done.
            if (w_done_nxt) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign serial_out  = r_serial;
    assign bit_valid   = r_bit_valid;
    assign frame_done  = r_done;
    assign frame_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_word_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_word_serializer
//  Description : Directed testbench for word_serializer. Two instances share
//                one stimulus: default parameters, and IDLE_BIT=1 with a
//                2-bit frame counter. A model of the downstream serial-in
//                shift register checks the parallel word at frame_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_word_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_data;

    logic        rdy0, ser0, bv0, done0;
    logic [15:0] cnt0;
    logic        rdy1, ser1, bv1, done1;
    logic [1:0]  cnt1;

    logic [3:0]  r_sr = 4'h0;

    int n_checks = 0;
    int n_fail   = 0;
    int m_frames = 0;

    always #5 clk = ~clk;

    word_serializer #(.WIDTH(4), .IDLE_BIT(1'b0), .COUNT_WIDTH(16)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (rdy0),
        .in_data    (in_data),
        .serial_out (ser0),
        .bit_valid  (bv0),
        .frame_done (done0),
        .frame_count(cnt0)
    );

    word_serializer #(.WIDTH(4), .IDLE_BIT(1'b1), .COUNT_WIDTH(2)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (rdy1),
        .in_data    (in_data),
        .serial_out (ser1),
        .bit_valid  (bv1),
        .frame_done (done1),
        .frame_count(cnt1)
    );

    // Downstream serial-in shift register: shifts every cycle, new bit at MSB.
    always @(posedge clk) r_sr <= {ser0, r_sr[3:1]};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, check in_ready in that cycle, clock, then
    // check the registered outputs produced by that edge.
    task automatic step(input logic v, input logic [3:0] d, input logic e_rdy,
                        input logic e_ser, input logic e_bv, input logic e_done,
                        input logic [3:0] e_word);
        in_valid = v;
        in_data  = d;
        chk("in_ready0", {15'd0, rdy0}, {15'd0, e_rdy});
        chk("in_ready1", {15'd0, rdy1}, {15'd0, e_rdy});
        @(posedge clk); #1;
        chk("serial0",   {15'd0, ser0},  {15'd0, (e_bv ? e_ser : 1'b0)});
        chk("serial1",   {15'd0, ser1},  {15'd0, (e_bv ? e_ser : 1'b1)});
        chk("bit_valid0",{15'd0, bv0},   {15'd0, e_bv});
        chk("bit_valid1",{15'd0, bv1},   {15'd0, e_bv});
        chk("frame_done0",{15'd0, done0},{15'd0, e_done});
        chk("frame_done1",{15'd0, done1},{15'd0, e_done});
        if (e_done) begin
            m_frames++;
            chk("parallel_out", {12'd0, r_sr}, {12'd0, e_word});
        end
        chk("frame_count0", cnt0, 16'(m_frames));
        chk("frame_count1", {14'd0, cnt1}, 16'(m_frames % 4));
    endtask

    // Two reset cycles with in_valid held high: no word may be accepted.
    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'hE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_frames = 0;
        chk("rst_serial0",  {15'd0, ser0},  16'd0);
        chk("rst_serial1",  {15'd0, ser1},  16'd1);
        chk("rst_bit_valid",{15'd0, bv0 | bv1}, 16'd0);
        chk("rst_done",     {15'd0, done0 | done1}, 16'd0);
        chk("rst_count0",   cnt0, 16'd0);
        chk("rst_count1",   {14'd0, cnt1}, 16'd0);
        chk("rst_ready",    {14'd0, rdy0, rdy1}, 16'd3);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        do_reset();
        step(0, 4'h0, 1, 0, 0, 0, 4'h0);

        // Single word 4'b1011 -> 1,1,0,1
        step(1, 4'hB, 1, 1, 1, 0, 4'h0);
        step(0, 4'h0, 0, 1, 1, 0, 4'h0);
        step(0, 4'h0, 0, 0, 1, 0, 4'h0);
        step(0, 4'h0, 0, 1, 1, 0, 4'h0);
        step(0, 4'h0, 1, 0, 0, 1, 4'hB);
        step(0, 4'h0, 1, 0, 0, 0, 4'h0);

        // Back-to-back A then 5 -> 0,1,0,1,1,0,1,0 with no gap
        step(1, 4'hA, 1, 0, 1, 0, 4'h0);
        step(1, 4'h5, 0, 1, 1, 0, 4'h0);
        step(1, 4'h5, 0, 0, 1, 0, 4'h0);
        step(1, 4'h5, 0, 1, 1, 0, 4'h0);
        step(1, 4'h5, 1, 1, 1, 1, 4'hA);
        step(0, 4'h0, 0, 0, 1, 0, 4'h0);
        step(0, 4'h0, 0, 1, 1, 0, 4'h0);
        step(0, 4'h0, 0, 0, 1, 0, 4'h0);
        step(0, 4'h0, 1, 0, 0, 1, 4'h5);
        step(0, 4'h0, 1, 0, 0, 0, 4'h0);

        // Backpressure: 9 in flight, data changes C then 3; 3 taken on last bit
        step(1, 4'h9, 1, 1, 1, 0, 4'h0);
        step(1, 4'hC, 0, 0, 1, 0, 4'h0);
        step(1, 4'h3, 0, 0, 1, 0, 4'h0);
        step(1, 4'h3, 0, 1, 1, 0, 4'h0);
        step(1, 4'h3, 1, 1, 1, 1, 4'h9);
        step(0, 4'h0, 0, 1, 1, 0, 4'h0);
        step(0, 4'h0, 0, 0, 1, 0, 4'h0);
        step(0, 4'h0, 0, 0, 1, 0, 4'h0);
        step(0, 4'h0, 1, 0, 0, 1, 4'h3);
        step(0, 4'h0, 1, 0, 0, 0, 4'h0);

        // Reset after two bits of F: frame abandoned, no frame_done
        step(1, 4'hF, 1, 1, 1, 0, 4'h0);
        step(0, 4'h0, 0, 1, 1, 0, 4'h0);
        do_reset();
        step(0, 4'h0, 1, 0, 0, 0, 4'h0);
        step(0, 4'h0, 1, 0, 0, 0, 4'h0);
        step(0, 4'h0, 1, 0, 0, 0, 4'h0);

        // New word 6 after reset -> 0,1,1,0
        step(1, 4'h6, 1, 0, 1, 0, 4'h0);
        step(0, 4'h0, 0, 1, 1, 0, 4'h0);
        step(0, 4'h0, 0, 1, 1, 0, 4'h0);
        step(0, 4'h0, 0, 0, 1, 0, 4'h0);
        step(0, 4'h0, 1, 0, 0, 1, 4'h6);
        step(0, 4'h0, 1, 0, 0, 0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial front end for the `shift_register` chain. It accepts WIDTH-bit words over a valid/ready handshake and drives them out one bit per cycle, LSB first. When a frame completes, the downstream serial-in shift register (which shifts every cycle, with no enable) holds the word unchanged on its `parallel_out`. A `frame_done` strobe marks the single cycle in which that parallel word is valid for consumers.

## Interface
- `WIDTH`, default 4: word width and bits per frame. Must be ≥ 2.
- `IDLE_BIT`, default 1'b0: level driven on `serial_out` while no frame is active.
- `COUNT_WIDTH`, default 16: width of the completed-frame counter.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock for all state.
- `rst_n`  in  1  synchronous active-low reset, sampled on `clk`.
- `in_valid`  in  1  upstream word available.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  WIDTH  word to serialize. Sampled only on accept.
- `serial_out`  out  1  registered serial bit. Connects to `serial_in` of the shift register.
- `bit_valid`  out  1  high while `serial_out` carries a frame bit.
- `frame_done`  out  1  one-cycle pulse. The downstream `parallel_out` equals the last word in this cycle.
- `frame_count`  out  COUNT_WIDTH  number of frames completed, modulo 2^COUNT_WIDTH.

## Operation
- Accept occurs when `in_valid && in_ready` at a rising edge. `in_data` is then loaded into an internal shift register.
- FSM states:
  - IDLE:
    - `in_ready`=1, `bit_valid`=0, `serial_out`=`IDLE_BIT`.
    - On accept → SHIFT, with bit counter = 0.
  - SHIFT:
    - `serial_out` = current LSB of the shift register. `bit_valid`=1.
    - Each cycle: shift right by one and increment the counter.
    - On the cycle where counter = WIDTH-1, the last bit is on `serial_out`.
  - Leaving SHIFT after the last bit:
    - If accepted in the same cycle → reload, stay in SHIFT, counter = 0.
    - Otherwise → IDLE.
- `in_ready` = (state==IDLE) || (state==SHIFT && counter==WIDTH-1). This makes back-to-back words produce a gap-free bit stream.
- Bit counter width is $clog2(WIDTH). It never exceeds WIDTH-1.
- `frame_done` is registered. It pulses the cycle after the last bit of each frame, independent of whether a new frame started.
- `frame_count` increments by 1 in the same cycle `frame_done` asserts. It wraps from 2^COUNT_WIDTH-1 to 0.
- `in_data` changes while `in_valid` is low or `in_ready` is low have no effect.

Reset (`rst_n`=0 at an edge):
- Next cycle: state = IDLE, `serial_out`=`IDLE_BIT`, `bit_valid`=0, `frame_done`=0, `frame_count`=0, `in_ready`=1.
- Reset mid-frame abandons the partial frame. No `frame_done` pulse is produced for it.
- While reset is asserted, the handshake is ignored (no accept).

## Timing
- Word accepted at edge t:
  - bit i is on `serial_out` during cycle t+1+i, for i = 0..WIDTH-1.
  - The downstream register captures bit i at the end of that cycle.
- `frame_done` = 1 during cycle t+WIDTH+1. Downstream `parallel_out` == accepted word in that same cycle.
- Latency from accept to first bit: 1 cycle. Accept to `frame_done`: WIDTH+1 cycles.
- Sustained throughput is one word per WIDTH cycles. There is zero idle gap when `in_valid` is held high.
- All outputs are registered except `in_ready`, which is combinational from state and counter only, never from `in_valid`.

## Test plan
- Single word, WIDTH=4, `in_data`=4'b1011:
  - `serial_out` = 1,1,0,1 over cycles t+1..t+4, with `bit_valid` high for exactly those 4 cycles.
  - `frame_done` at t+5, where `parallel_out`=4'hB and `frame_count`=1.
- Back-to-back 4'hA then 4'h5 with `in_valid` held:
  - Stream 0,1,0,1,1,0,1,0 with no gap.
  - `in_ready` is high only in IDLE and on cycle t+4.
  - `frame_done` pulses at t+5 and t+9, with `parallel_out` = 4'hA then 4'h5.
- Backpressure: `in_valid`=1 with `in_data` changed to 4'h3 mid-frame:
  - The word is not consumed until the last-bit cycle.
  - The in-flight frame's bits are unchanged.
- Reset mid-frame: assert `rst_n`=0 after 2 bits of 4'hF:
  - Next cycle, `serial_out`=`IDLE_BIT`, `bit_valid`=0, `frame_count`=0.
  - No `frame_done` pulse.
  - A new word sent after reset serializes correctly.
- Counter wrap, COUNT_WIDTH=2: 5 frames → `frame_count` sequence 1,2,3,0,1.
- Idle level, IDLE_BIT=1: `serial_out` is 1 before and between frames separated by idle cycles, and `bit_valid` is 0 there.
